// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
//    Shared definitions for the byte-wide RAM sequencer: FSM state encodings,
//    request owner codes, the implicit fetch lane select, and a byte-lane helper.
//    No ports; imported by mem_ctrl and mem_lane_pick.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_MEM = 1'b1
   } owner_t;

   // Instruction fetch always moves a full word.
   localparam logic [3:0] SEL_WORD = 4'b1111;

   // Byte lane i of a 32-bit word (lane i = bits 8i+7:8i).
   function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
      return word[{lane, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/mem_ctrl_lane_pick.sv
// mem_lane_pick
//    Combinational lane selector for the byte sequencer. Given the mask of lanes
//    still to be accessed, returns the lowest set lane and whether it is the only
//    one left. An all-zero mask returns lane 0 with last=1; the controller never
//    issues from an empty mask.
// Ports
//    mask  in   4   lanes still pending, bit i = byte lane i
//    lane  out  2   index of the lowest pending lane
//    last  out  1   1 when that lane is the final pending one
module mem_lane_pick
   import mem_ctrl_pkg::*;
(
   input  logic [3:0] mask,
   output logic [1:0] lane,
   output logic       last
);

   // Priority encode the lowest set bit; last when at most one bit is set.
   always_comb begin
      lane = 2'd0;
      if (mask[0]) begin
         lane = 2'd0;
      end else if (mask[1]) begin
         lane = 2'd1;
      end else if (mask[2]) begin
         lane = 2'd2;
      end else if (mask[3]) begin
         lane = 2'd3;
      end else begin
         lane = 2'd0;
      end
      last = ((mask & (mask - 4'd1)) == 4'd0);
   end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl
//    Arbitrates one byte-wide synchronous RAM port between instruction fetch and
//    the MEM stage. A granted 32-bit request is split into one RAM access per set
//    select lane (ascending), read bytes are reassembled in lane position, and a
//    one-cycle done pulse returns the word to the owner. MEM wins simultaneous
//    requests. Sign/zero extension stays in the MEM stage.
// Ports
//    clk, rst                        clock (rising edge), synchronous active-low reset
//    if_req/if_addr                  fetch request (select implicitly 4'b1111)
//    if_rdata/if_done                fetched word and its completion pulse
//    mem_req/mem_we/mem_addr/
//    mem_sel/mem_wdata               MEM stage load/store request
//    mem_rdata/mem_done              load word (unselected lanes 0) and completion pulse
//    ram_en/ram_we/ram_addr/
//    ram_wdata/ram_rdata             byte RAM port, read data one cycle after ram_en
//    stall_req                       high while a request is waiting or in flight
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [31:0]       if_rdata,
   output logic              if_done,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [3:0]        mem_sel,
   input  logic [31:0]       mem_wdata,
   output logic [31:0]       mem_rdata,
   output logic              mem_done,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata,
   output logic              stall_req
);

   state_t              state_r, state_n;
   owner_t              owner_r, owner_n;
   logic                we_r, we_n;
   logic [ADDR_W-3:0]   word_r, word_n;       // word base without the two zero bits
   logic [3:0]          pend_r, pend_n;       // lanes not yet issued
   logic [31:0]         wdata_r, wdata_n;
   logic [31:0]         asm_r, asm_n;         // read word assembly
   logic [1:0]          lane_r, lane_n;       // lane currently on the RAM port
   logic                last_r, last_n;       // lane_r is the final lane of the request
   logic                rd_pend_r, rd_pend_n; // a read was issued last cycle
   logic [1:0]          rd_lane_r, rd_lane_n;

   logic                ram_en_r, ram_en_n;
   logic                ram_we_r, ram_we_n;
   logic [ADDR_W-1:0]   ram_addr_r, ram_addr_n;
   logic [7:0]          ram_wdata_r, ram_wdata_n;
   logic                if_done_r, if_done_n;
   logic [31:0]         if_rdata_r, if_rdata_n;
   logic                mem_done_r, mem_done_n;
   logic [31:0]         mem_rdata_r, mem_rdata_n;

   logic [1:0]          pick_lane_s;
   logic                pick_last_s;
   logic                iss_s;                // drive a RAM access next cycle
   logic                fin_s;                // pulse done next cycle
   logic [31:0]         fin_val_s;
   logic                unused_s;

   // Word alignment drops the low address bits.
   assign unused_s = ^{mem_addr[1:0], if_addr[1:0]};

   mem_lane_pick u_pick (
      .mask (pend_n),
      .lane (pick_lane_s),
      .last (pick_last_s)
   );

   // Pending lane mask for the next cycle: loaded on grant, one bit retired per issue.
   always_comb begin
      pend_n = pend_r;
      case (state_r)
         S_IDLE: begin
            if (mem_req) begin
               pend_n = mem_sel;
            end else if (if_req) begin
               pend_n = SEL_WORD;
            end else begin
               pend_n = pend_r;
            end
         end
         S_ISSUE: pend_n = pend_r & ~(4'b0001 << lane_r);
         default: pend_n = pend_r;
      endcase
   end

   // Next-state, request latching, read assembly and next registered outputs.
   always_comb begin
      state_n     = state_r;
      owner_n     = owner_r;
      we_n        = we_r;
      word_n      = word_r;
      wdata_n     = wdata_r;
      lane_n      = lane_r;
      last_n      = last_r;
      iss_s       = 1'b0;
      fin_s       = 1'b0;
      fin_val_s   = 32'd0;
      ram_en_n    = 1'b0;
      ram_we_n    = 1'b0;
      ram_addr_n  = '0;
      ram_wdata_n = 8'd0;
      if_done_n   = 1'b0;
      if_rdata_n  = 32'd0;
      mem_done_n  = 1'b0;
      mem_rdata_n = 32'd0;
      // A byte read in the previous cycle is on ram_rdata now.
      rd_pend_n   = ram_en_r & ~ram_we_r;
      rd_lane_n   = lane_r;
      asm_n       = asm_r;
      if (rd_pend_r) begin
         asm_n[{rd_lane_r, 3'b000} +: 8] = ram_rdata;
      end else begin
         asm_n = asm_r;
      end

      case (state_r)
         S_IDLE: begin
            if (mem_req) begin
               owner_n = OWN_MEM;
               we_n    = mem_we;
               word_n  = mem_addr[ADDR_W-1:2];
               wdata_n = mem_wdata;
            end else if (if_req) begin
               owner_n = OWN_IF;
               we_n    = 1'b0;
               word_n  = if_addr[ADDR_W-1:2];
               wdata_n = 32'd0;
            end else begin
               owner_n = owner_r;
            end
            if (mem_req || if_req) begin
               asm_n = 32'd0;
               if (pend_n == 4'b0000) begin
                  state_n = S_DONE;
                  fin_s   = 1'b1;
               end else begin
                  state_n = S_ISSUE;
                  iss_s   = 1'b1;
               end
            end else begin
               state_n = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (last_r) begin
               if (we_r) begin
                  state_n = S_DONE;
                  fin_s   = 1'b1;
               end else begin
                  state_n = S_WAIT;
               end
            end else begin
               state_n = S_ISSUE;
               iss_s   = 1'b1;
            end
         end
         S_WAIT: begin
            // The final byte lands in asm_n on this edge.
            state_n   = S_DONE;
            fin_s     = 1'b1;
            fin_val_s = asm_n;
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase

      if (iss_s) begin
         ram_en_n    = 1'b1;
         ram_we_n    = we_n;
         ram_addr_n  = {word_n, pick_lane_s};
         ram_wdata_n = lane_byte(wdata_n, pick_lane_s);
         lane_n      = pick_lane_s;
         last_n      = pick_last_s;
      end else begin
         ram_en_n    = 1'b0;
      end

      if (fin_s) begin
         if (owner_n == OWN_MEM) begin
            mem_done_n  = 1'b1;
            mem_rdata_n = fin_val_s;
         end else begin
            if_done_n   = 1'b1;
            if_rdata_n  = fin_val_s;
         end
      end else begin
         mem_done_n = 1'b0;
      end
   end

   // State, datapath and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= S_IDLE;
         owner_r     <= OWN_IF;
         we_r        <= 1'b0;
         word_r      <= '0;
         pend_r      <= 4'd0;
         wdata_r     <= 32'd0;
         asm_r       <= 32'd0;
         lane_r      <= 2'd0;
         last_r      <= 1'b0;
         rd_pend_r   <= 1'b0;
         rd_lane_r   <= 2'd0;
         ram_en_r    <= 1'b0;
         ram_we_r    <= 1'b0;
         ram_addr_r  <= '0;
         ram_wdata_r <= 8'd0;
         if_done_r   <= 1'b0;
         if_rdata_r  <= 32'd0;
         mem_done_r  <= 1'b0;
         mem_rdata_r <= 32'd0;
      end else begin
         state_r     <= state_n;
         owner_r     <= owner_n;
         we_r        <= we_n;
         word_r      <= word_n;
         pend_r      <= pend_n;
         wdata_r     <= wdata_n;
         asm_r       <= asm_n;
         lane_r      <= lane_n;
         last_r      <= last_n;
         rd_pend_r   <= rd_pend_n;
         rd_lane_r   <= rd_lane_n;
         ram_en_r    <= ram_en_n;
         ram_we_r    <= ram_we_n;
         ram_addr_r  <= ram_addr_n;
         ram_wdata_r <= ram_wdata_n;
         if_done_r   <= if_done_n;
         if_rdata_r  <= if_rdata_n;
         mem_done_r  <= mem_done_n;
         mem_rdata_r <= mem_rdata_n;
      end
   end

   assign ram_en    = ram_en_r;
   assign ram_we    = ram_we_r;
   assign ram_addr  = ram_addr_r;
   assign ram_wdata = ram_wdata_r;
   assign if_done   = if_done_r;
   assign if_rdata  = if_rdata_r;
   assign mem_done  = mem_done_r;
   assign mem_rdata = mem_rdata_r;

   // Low in DONE so the pipeline advances on that edge.
   assign stall_req = ((state_r == S_IDLE) & (mem_req | if_req)) |
                      (state_r == S_ISSUE) | (state_r == S_WAIT);

endmodule
